// File: rtl/atm_pkg.sv
// Shared ATM definitions: one-hot controller states, message IDs, character codes
// and the state-to-message map used by the display scheduler.
package atm_pkg;

    localparam logic [15:0] ST_WELCOME                   = 16'h0001;
    localparam logic [15:0] ST_MENU                      = 16'h0002;
    localparam logic [15:0] ST_ACC_NUM                   = 16'h0004;
    localparam logic [15:0] ST_PIN_INPUT                 = 16'h0008;
    localparam logic [15:0] ST_TRANSFER                  = 16'h0010;
    localparam logic [15:0] ST_WITHDRAW                  = 16'h0020;
    localparam logic [15:0] ST_SELECT_AMOUNT_WITHDRAW    = 16'h0040;
    localparam logic [15:0] ST_SELECT_AMOUNT_TRANSFER    = 16'h0080;
    localparam logic [15:0] ST_CONVERT_CURRENCY          = 16'h0100;
    localparam logic [15:0] ST_SELECT_CURRENCY_CONVERT_1 = 16'h0200;
    localparam logic [15:0] ST_SELECT_CURRENCY_CONVERT_2 = 16'h0400;
    localparam logic [15:0] ST_SELECT_CURRENCY_TRANSFER  = 16'h0800;
    localparam logic [15:0] ST_ERROR                     = 16'h1000;
    localparam logic [15:0] ST_SUCCESS                   = 16'h2000;
    localparam logic [15:0] ST_BALANCE                   = 16'h4000;
    localparam logic [15:0] ST_LOGOUT                    = 16'h8000;

    localparam logic [2:0] MSG_BLANK    = 3'd0;
    localparam logic [2:0] MSG_ACCOUNT  = 3'd1;
    localparam logic [2:0] MSG_PIN      = 3'd2;
    localparam logic [2:0] MSG_AMOUNT   = 3'd3;
    localparam logic [2:0] MSG_CURRENCY = 3'd4;
    localparam logic [2:0] MSG_ERROR    = 3'd5;
    localparam logic [2:0] MSG_SUCCESS  = 3'd6;

    localparam logic [4:0] CHAR_BLANK = 5'd0;
    localparam logic [4:0] CHAR_0 = 5'd1,  CHAR_1 = 5'd2,  CHAR_2 = 5'd3,  CHAR_3 = 5'd4;
    localparam logic [4:0] CHAR_4 = 5'd5,  CHAR_5 = 5'd6,  CHAR_6 = 5'd7,  CHAR_7 = 5'd8;
    localparam logic [4:0] CHAR_8 = 5'd9,  CHAR_9 = 5'd10, CHAR_A = 5'd11, CHAR_B = 5'd12;
    localparam logic [4:0] CHAR_C = 5'd13, CHAR_D = 5'd14, CHAR_E = 5'd15, CHAR_F = 5'd16;
    localparam logic [4:0] CHAR_G = 5'd17, CHAR_H = 5'd18, CHAR_I = 5'd19, CHAR_J = 5'd20;
    localparam logic [4:0] CHAR_L = 5'd21, CHAR_N = 5'd22, CHAR_O = 5'd23, CHAR_P = 5'd24;
    localparam logic [4:0] CHAR_R = 5'd25, CHAR_S = 5'd26, CHAR_T = 5'd27, CHAR_U = 5'd28;
    localparam logic [4:0] CHAR_Y = 5'd29, CHAR_Z = 5'd30, CHAR_DASH = 5'd31;

    typedef enum logic [1:0] {
        DSP_IDLE,
        DSP_FETCH,
        DSP_LATCH,
        DSP_HOLD
    } disp_state_e;

    // Zero and multi-hot states fall through to the blank message.
    function automatic logic [2:0] msg_of_state(input logic [15:0] st);
        case (st)
            ST_ACC_NUM, ST_TRANSFER:                            return MSG_ACCOUNT;
            ST_PIN_INPUT:                                       return MSG_PIN;
            ST_WITHDRAW, ST_SELECT_AMOUNT_WITHDRAW,
            ST_SELECT_AMOUNT_TRANSFER, ST_SELECT_CURRENCY_CONVERT_1: return MSG_AMOUNT;
            ST_CONVERT_CURRENCY, ST_SELECT_CURRENCY_CONVERT_2,
            ST_SELECT_CURRENCY_TRANSFER:                        return MSG_CURRENCY;
            ST_ERROR:                                           return MSG_ERROR;
            ST_SUCCESS:                                         return MSG_SUCCESS;
            default:                                            return MSG_BLANK;
        endcase
    endfunction

endpackage

// File: rtl/char_to_seg.sv
// 5-bit character code to active-low seven-segment pattern {g,f,e,d,c,b,a}.
module char_to_seg
    import atm_pkg::*;
(
    input  logic [4:0] code_i,
    output logic [6:0] seg_o
);

    always_comb begin
        seg_o = 7'h7F;
        case (code_i)
            CHAR_BLANK: seg_o = 7'h7F;
            CHAR_0:     seg_o = 7'h40;
            CHAR_1:     seg_o = 7'h79;
            CHAR_2:     seg_o = 7'h24;
            CHAR_3:     seg_o = 7'h30;
            CHAR_4:     seg_o = 7'h19;
            CHAR_5:     seg_o = 7'h12;
            CHAR_6:     seg_o = 7'h02;
            CHAR_7:     seg_o = 7'h78;
            CHAR_8:     seg_o = 7'h00;
            CHAR_9:     seg_o = 7'h10;
            CHAR_A:     seg_o = 7'h08;
            CHAR_B:     seg_o = 7'h03;
            CHAR_C:     seg_o = 7'h46;
            CHAR_D:     seg_o = 7'h21;
            CHAR_E:     seg_o = 7'h06;
            CHAR_F:     seg_o = 7'h0E;
            CHAR_G:     seg_o = 7'h42;
            CHAR_H:     seg_o = 7'h09;
            CHAR_I:     seg_o = 7'h4F;
            CHAR_J:     seg_o = 7'h61;
            CHAR_L:     seg_o = 7'h47;
            CHAR_N:     seg_o = 7'h2B;
            CHAR_O:     seg_o = 7'h23;
            CHAR_P:     seg_o = 7'h0C;
            CHAR_R:     seg_o = 7'h2F;
            CHAR_S:     seg_o = 7'h12;
            CHAR_T:     seg_o = 7'h07;
            CHAR_U:     seg_o = 7'h41;
            CHAR_Y:     seg_o = 7'h11;
            CHAR_Z:     seg_o = 7'h24;
            CHAR_DASH:  seg_o = 7'h3F;
            default:    seg_o = 7'h7F;
        endcase
    end

endmodule

// File: rtl/scroll_display_ctrl.sv
// Scrolling 8-digit display scheduler: picks the message for the ATM state, fetches
// its characters from an external registered ROM and multiplexes them onto the digits.
module scroll_display_ctrl
    import atm_pkg::*;
#(
    parameter int unsigned SCAN_DIV = 4096,
    parameter int unsigned STEP_DIV = 50_000_000,
    parameter int unsigned MSG_LEN  = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] state,
    output logic [6:0]  rom_addr,
    input  logic [4:0]  rom_data,
    output logic [7:0]  AN,
    output logic [6:0]  led,
    output logic [2:0]  msg_id
);

    localparam int unsigned HOLD_W   = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned STEP_W   = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [3:0]  IDX_MASK = 4'(MSG_LEN - 1);

    disp_state_e       fsm_q;
    logic [2:0]        msg_id_q;
    logic [3:0]        offset_q;
    logic [2:0]        d_q;
    logic [HOLD_W-1:0] hold_cnt_q;
    logic [STEP_W-1:0] step_cnt_q;
    logic              step_pending_q;
    logic [7:0]        an_q;
    logic [6:0]        led_q;
    logic [6:0]        rom_addr_q;

    logic [2:0] msg_d;
    logic [2:0] d_d;
    logic [3:0] offset_d;
    logic [3:0] fetch_idx;
    logic [6:0] seg;
    logic       step_tc;
    logic       hold_done;
    logic       advance;

    char_to_seg u_char_to_seg (
        .code_i (rom_data),
        .seg_o  (seg)
    );

    always_comb begin
        msg_d     = msg_of_state(state);
        step_tc   = (msg_id_q != '0) && (step_cnt_q == STEP_W'(STEP_DIV - 1));
        hold_done = (hold_cnt_q == HOLD_W'(SCAN_DIV - 1));
        d_d       = d_q + 3'd1;
        // Scroll only at the frame boundary so a frame never mixes two offsets.
        advance   = (d_q == 3'd7) && step_pending_q;
        offset_d  = (offset_q + {3'b000, advance}) & IDX_MASK;
        fetch_idx = (offset_d + {1'b0, d_d}) & IDX_MASK;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fsm_q          <= DSP_IDLE;
            msg_id_q       <= '0;
            offset_q       <= '0;
            d_q            <= '0;
            hold_cnt_q     <= '0;
            step_cnt_q     <= '0;
            step_pending_q <= 1'b0;
            an_q           <= '1;
            led_q          <= '1;
            rom_addr_q     <= '0;
        end else begin
            if (msg_id_q != '0) begin
                if (step_tc) begin
                    step_cnt_q     <= '0;
                    step_pending_q <= 1'b1;
                end else begin
                    step_cnt_q <= step_cnt_q + 1'b1;
                end
            end

            if (msg_d != msg_id_q) begin
                msg_id_q       <= msg_d;
                offset_q       <= '0;
                step_cnt_q     <= '0;
                step_pending_q <= 1'b0;
                d_q            <= '0;
                hold_cnt_q     <= '0;
                an_q           <= '1;
                led_q          <= '1;
                rom_addr_q     <= {msg_d, 4'd0};
                fsm_q          <= (msg_d == '0) ? DSP_IDLE : DSP_FETCH;
            end else begin
                case (fsm_q)
                    DSP_IDLE: begin
                        an_q  <= '1;
                        led_q <= '1;
                        if (msg_id_q != '0) begin
                            rom_addr_q <= {msg_id_q, (offset_q + {1'b0, d_q}) & IDX_MASK};
                            fsm_q      <= DSP_FETCH;
                        end
                    end
                    DSP_FETCH: fsm_q <= DSP_LATCH;
                    DSP_LATCH: begin
                        led_q      <= seg;
                        an_q       <= ~(8'h80 >> d_q);
                        hold_cnt_q <= '0;
                        fsm_q      <= DSP_HOLD;
                    end
                    DSP_HOLD: begin
                        if (hold_done) begin
                            d_q        <= d_d;
                            offset_q   <= offset_d;
                            an_q       <= '1;
                            led_q      <= '1;
                            rom_addr_q <= {msg_id_q, fetch_idx};
                            fsm_q      <= DSP_FETCH;
                            // A terminal count landing on this edge stays pending for the next frame.
                            if (advance && !step_tc) step_pending_q <= 1'b0;
                        end else begin
                            hold_cnt_q <= hold_cnt_q + 1'b1;
                        end
                    end
                    default: fsm_q <= DSP_IDLE;
                endcase
            end
        end
    end

    assign AN       = an_q;
    assign led      = led_q;
    assign rom_addr = rom_addr_q;
    assign msg_id   = msg_id_q;

endmodule

// File: tb/tb_scroll_display_ctrl.sv
// Randomized check of the scroll scheduler against a time-based reference model
// (message, frame/slot position and scroll offset derived arithmetically from elapsed cycles).
module tb_scroll_display_ctrl;
    import atm_pkg::*;

    localparam int SCAN  = 4;
    localparam int STEP  = 37;
    localparam int SLOT  = SCAN + 2;
    localparam int FRAME = 8 * SLOT;

    typedef struct {
        logic        rst;
        logic [15:0] st;
        int          cycles;
    } seg_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] state;
    logic [6:0]  rom_addr;
    logic [4:0]  rom_data;
    logic [7:0]  AN;
    logic [6:0]  led;
    logic [2:0]  msg_id;

    logic [4:0]  rom_mem [128];
    seg_t        plan [$];
    int          n_chk = 0;
    int          n_err = 0;
    int          m_msg = 0;
    int          m_n   = 0;

    // Lit segments per character code, as letters a..g.
    string seg_tbl [32] = '{"", "abcdef", "bc", "abdeg", "abcdg", "bcfg", "acdfg", "acdefg",
                            "abc", "abcdefg", "abcdfg", "abcefg", "cdefg", "adef", "bcdeg",
                            "adefg", "aefg", "acdef", "bcefg", "ef", "bcde", "def", "ceg",
                            "cdeg", "abefg", "eg", "acdfg", "defg", "bcdef", "bcdfg", "abdeg", "g"};

    scroll_display_ctrl #(
        .SCAN_DIV (SCAN),
        .STEP_DIV (STEP),
        .MSG_LEN  (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .state    (state),
        .rom_addr (rom_addr),
        .rom_data (rom_data),
        .AN       (AN),
        .led      (led),
        .msg_id   (msg_id)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom_mem[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (msg %0d, cycle %0d)", tag, got, exp, m_msg, m_n);
        end
    endtask

    function automatic logic [6:0] seg_ref(input int code);
        logic [6:0] lit = '0;
        string s = seg_tbl[code];
        for (int i = 0; i < s.len(); i++) lit[s.getc(i) - 8'h61] = 1'b1;
        return ~lit;
    endfunction

    function automatic int msg_ref(input logic [15:0] s);
        if (s inside {ST_ACC_NUM, ST_TRANSFER}) return 1;
        if (s == ST_PIN_INPUT) return 2;
        if (s inside {ST_WITHDRAW, ST_SELECT_AMOUNT_WITHDRAW, ST_SELECT_AMOUNT_TRANSFER,
                      ST_SELECT_CURRENCY_CONVERT_1}) return 3;
        if (s inside {ST_CONVERT_CURRENCY, ST_SELECT_CURRENCY_CONVERT_2,
                      ST_SELECT_CURRENCY_TRANSFER}) return 4;
        if (s == ST_ERROR) return 5;
        if (s == ST_SUCCESS) return 6;
        return 0;
    endfunction

    // Terminal counts fall on cycles STEP, 2*STEP, ... after the message starts; frame k
    // scrolls if at least one of them landed in the previous frame [(k-1)*FRAME, k*FRAME).
    function automatic int offset_at(input int frame);
        int off = 0;
        for (int k = 1; k <= frame; k++) begin
            int a  = (k - 1) * FRAME;
            int hi = (k * FRAME - 1) / STEP;
            int lo = (a == 0) ? 0 : (a - 1) / STEP;
            if (hi > lo) off++;
        end
        return off % 16;
    endfunction

    task automatic check_outputs();
        int dg, p, idx;
        check_eq("msg_id", 32'(msg_id), 32'(m_msg));
        if (m_msg == 0) begin
            check_eq("idle_AN", 32'(AN), 32'hFF);
            check_eq("idle_led", 32'(led), 32'h7F);
            check_eq("idle_rom_addr", 32'(rom_addr), 32'h0);
        end else begin
            dg  = (m_n % FRAME) / SLOT;
            p   = m_n % SLOT;
            idx = (offset_at(m_n / FRAME) + dg) % 16;
            if (p == 0) check_eq("fetch_rom_addr", 32'(rom_addr), 32'(m_msg * 16 + idx));
            if (p < 2) begin
                check_eq("blank_AN", 32'(AN), 32'hFF);
                check_eq("blank_led", 32'(led), 32'h7F);
            end else begin
                check_eq("lit_AN", 32'(AN), 32'(8'hFF ^ (8'h80 >> dg)));
                check_eq("lit_led", 32'(led), 32'(seg_ref(int'(rom_mem[m_msg * 16 + idx]))));
            end
        end
    endtask

    function automatic void add(input logic r, input logic [15:0] st, input int cycles);
        seg_t s;
        s.rst = r;
        s.st = st;
        s.cycles = cycles;
        plan.push_back(s);
    endfunction

    initial begin
        logic [15:0] pool [$];
        rst   = 1'b1;
        state = '0;
        for (int i = 0; i < 128; i++) rom_mem[i] = 5'($urandom);
        for (int i = 0; i < 16; i++) begin
            rom_mem[32 + i] = 5'(i + 1);
            rom_mem[80 + i] = 5'(i);
            rom_mem[96 + i] = 5'(i + 16);
        end
        for (int i = 0; i < 16; i++) pool.push_back(16'h0001 << i);
        pool.push_back(16'h0000);
        pool.push_back(16'h0006);
        pool.push_back(16'($urandom));

        add(1'b1, ST_ACC_NUM, 3);
        add(1'b0, ST_ACC_NUM, 100);
        add(1'b0, ST_PIN_INPUT, 1900);
        add(1'b0, ST_ACC_NUM, 28);
        add(1'b0, ST_PIN_INPUT, 80);
        add(1'b0, ST_MENU, 20);
        add(1'b0, 16'h0000, 20);
        add(1'b0, 16'h0006, 20);
        add(1'b0, ST_ERROR, 400);
        add(1'b0, ST_SUCCESS, 400);
        add(1'b0, ST_PIN_INPUT, 63);
        add(1'b1, ST_PIN_INPUT, 1);
        add(1'b0, ST_PIN_INPUT, 150);
        for (int i = 0; i < 30; i++)
            add($urandom_range(0, 7) == 0, pool[$urandom_range(0, pool.size() - 1)],
                $urandom_range(1, 400));

        foreach (plan[s]) begin
            for (int c = 0; c < plan[s].cycles; c++) begin
                rst   = plan[s].rst;
                state = plan[s].st;
                if (rst) begin
                    m_msg = 0;
                    m_n   = 0;
                end else if (msg_ref(state) != m_msg) begin
                    m_msg = msg_ref(state);
                    m_n   = 0;
                end else begin
                    m_n++;
                end
                @(negedge clk);
                check_outputs();
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
